// File: rtl/data_mon_sched.sv
// data_mon_sched: sequences NCHIP DataMon readouts into one merged serial event stream.
// Define DMS_TIMEOUT_EN to add an IDLE watchdog that starts an event without stuck chips.
module data_mon_sched #(
    parameter int NCHIP = 12,
    parameter int LAT   = 2,
    parameter int TMO   = 1023
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Enable,
    input  logic [NCHIP-1:0]   Ready,
    input  logic [NCHIP-1:0]   FCL,
    input  logic [2*NCHIP-1:0] TagOut,
    input  logic [4*NCHIP-1:0] ChipNCL,
    input  logic [NCHIP-1:0]   Dout,
    output logic [NCHIP-1:0]   Send,
    output logic               SerOut,
    output logic               Busy,
    output logic               TagErr,
    output logic               TmoErr,
    output logic [15:0]        EvtCnt
);
    localparam int IW = NCHIP > 1 ? $clog2(NCHIP) : 1;

    typedef enum logic [3:0] {IDLE, CHK, HDR, SEL, SEND, GAP, FWD, NEXT, DONE} state_t;

    state_t             state, nxt;
    logic [IW-1:0]      cur, sel;
    logic [NCHIP-1:0]   served, fcl_l, fm, rdy_v, rdy_m;
    logic [4*NCHIP-1:0] ncl_l;
    logic [15:0]        hdr;
    logic [3:0]         hcnt;
    logic [7:0]         cnt, flen;
    logic               mism, wd_hit;

`ifdef DMS_TIMEOUT_EN
    localparam int WW = TMO > 1 ? $clog2(TMO + 1) : 1;
    logic [WW-1:0] wd;
    logic          tmo_cond;
    assign rdy_v    = Ready;
    assign tmo_cond = Enable && |Ready && !(&Ready);
    assign wd_hit   = tmo_cond && wd == WW'(TMO - 1);
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wd     <= '0;
            TmoErr <= 1'b0;
            rdy_m  <= '0;
        end else begin
            wd <= (state == IDLE && tmo_cond && !wd_hit) ? wd + 1'b1 : '0;
            if (state == IDLE && wd_hit) TmoErr <= 1'b1;
            if (state == CHK) rdy_m <= Ready;
        end
    end
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TMO;
    assign rdy_v      = '1;
    assign rdy_m      = '1;
    assign wd_hit     = 1'b0;
    assign TmoErr     = 1'b0;
`endif

    // Tag compare and next-chip pick work on live inputs; only CHK latches them.
    always_comb begin
        mism = 1'b0;
        for (int i = 1; i < NCHIP; i++)
            if (rdy_v[i] && TagOut[2*i +: 2] != TagOut[1:0]) mism = 1'b1;
        fm  = FCL & rdy_v;
        sel = '0;
        for (int i = NCHIP - 1; i >= 0; i--)
            if (!served[i]) sel = IW'(i);
    end

    assign flen = {4'd0, ncl_l[{cur, 2'b00} +: 4]} * 8'd12 + 8'd11;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (Enable && (&Ready || wd_hit)) ? CHK : IDLE;
            CHK:     nxt = HDR;
            HDR:     nxt = hcnt == 4'd15 ? SEL : HDR;
            SEL:     nxt = &served ? DONE : SEND;
            SEND:    nxt = !fcl_l[cur] ? NEXT : (LAT > 1 ? GAP : FWD);
            GAP:     nxt = cnt == 8'd0 ? FWD : GAP;
            FWD:     nxt = cnt == 8'd0 ? NEXT : FWD;
            NEXT:    nxt = SEL;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cur    <= '0;
            served <= '0;
            fcl_l  <= '0;
            ncl_l  <= '0;
            hdr    <= '0;
            hcnt   <= '0;
            cnt    <= '0;
            TagErr <= 1'b0;
            EvtCnt <= '0;
        end else begin
            case (state)
                CHK: begin
                    fcl_l  <= fm;
                    ncl_l  <= ChipNCL;
                    hdr    <= {1'b1, TagOut[1:0], mism, 12'(fm)};
                    hcnt   <= '0;
                    served <= '0;
                    if (mism) TagErr <= 1'b1;
                end
                HDR: begin
                    hdr  <= {hdr[14:0], 1'b0};
                    hcnt <= hcnt + 4'd1;
                end
                SEL:  cur <= sel;
                SEND: cnt <= LAT > 1 ? 8'(LAT - 2) : flen;
                GAP:  cnt <= cnt == 8'd0 ? flen : cnt - 8'd1;
                FWD:  if (cnt != 8'd0) cnt <= cnt - 8'd1;
                NEXT: served[cur] <= 1'b1;
                DONE: EvtCnt <= EvtCnt + 16'd1;
                default: ;
            endcase
        end
    end

    assign Busy   = state != IDLE;
    assign SerOut = state == HDR ? hdr[15] : (state == FWD ? Dout[cur] : 1'b0);
    assign Send   = (state == SEND && rdy_m[cur]) ? NCHIP'(1) << cur : '0;
endmodule

// File: tb/tb_data_mon_sched.sv
// tb_data_mon_sched: scoreboard bench; stimulus queues per-cycle expected SerOut/Send
// for each event, a monitor pops one entry per Busy cycle and compares.
module tb_data_mon_sched;
    localparam int LAT   = 2;
    localparam int TMO_T = 20;

    logic        Clock, Reset, Enable, SerOut, Busy, TagErr, TmoErr;
    logic [11:0] Ready, FCL, Dout, Send;
    logic [23:0] TagOut;
    logic [47:0] ChipNCL;
    logic [15:0] EvtCnt;

    data_mon_sched #(.NCHIP(12), .LAT(LAT), .TMO(TMO_T)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(Enable), .Ready(Ready), .FCL(FCL),
        .TagOut(TagOut), .ChipNCL(ChipNCL), .Dout(Dout), .Send(Send), .SerOut(SerOut),
        .Busy(Busy), .TagErr(TagErr), .TmoErr(TmoErr), .EvtCnt(EvtCnt)
    );

    typedef struct {logic ser; logic [11:0] snd;} exp_t;
    exp_t   q[$];
    exp_t   e;
    int     checks = 0, passes = 0;
    longint cyc = 0;
    longint st[12];
    int     len[12];
    logic [11:0] ev_fcl;
    logic [47:0] ev_ncl;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic pat(int i, longint j);
        return ((i + j) % 3) != 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Chip model: each chip streams its own pattern LAT cycles after its Send, 1s otherwise.
    initial for (int i = 0; i < 12; i++) begin st[i] = -1000; len[i] = 0; end
    always @(posedge Clock) begin
        cyc++;
        #1;
        for (int i = 0; i < 12; i++)
            Dout[i] = (cyc >= st[i] && cyc < st[i] + len[i]) ? pat(i, cyc - st[i]) : 1'b1;
    end

    always @(negedge Clock) begin
        for (int i = 0; i < 12; i++)
            if (Send[i] === 1'b1) begin
                st[i]  = cyc + LAT;
                len[i] = ev_fcl[i] ? 12 * (int'(ev_ncl[4*i +: 4]) + 1) : 0;
            end
        if (Reset === 1'b1) begin
            if (Busy === 1'b1) begin
                if (q.size() == 0) chk("extra_busy_cycle", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("serout", SerOut, e.ser);
                    chk("send", Send, e.snd);
                end
            end else chk("idle_out", {SerOut, Send}, 0);
        end
    end

    task automatic push(input logic s, input logic [11:0] p);
        q.push_back('{s, p});
    endtask

    task automatic run_ev(input logic [11:0] rdy, input logic [11:0] fcl, input logic [23:0] tags,
                          input logic [47:0] ncl, input int rst_chip);
        logic [11:0] m;
        logic [15:0] h;
        logic        mm;
        int          n, seen;
        mm = 1'b0;
        for (int i = 0; i < 12; i++) if (tags[2*i +: 2] != tags[1:0]) mm = 1'b1;
        m = fcl & rdy;
        h = {1'b1, tags[1:0], mm, m};
        push(0, 0);
        for (int b = 15; b >= 0; b--) push(h[b], 0);
        for (int i = 0; i < 12; i++) begin
            push(0, 0);
            push(0, rdy[i] ? (12'b1 << i) : 12'b0);
            if (m[i]) begin
                for (int g = 0; g < LAT - 1; g++) push(0, 0);
                for (int j = 0; j < 12 * (int'(ncl[4*i +: 4]) + 1); j++) push(pat(i, j), 0);
            end
            push(0, 0);
        end
        push(0, 0);
        push(0, 0);
        ev_fcl = m;
        ev_ncl = ncl;
        @(negedge Clock);
        #1;
        Ready = rdy; FCL = fcl; TagOut = tags; ChipNCL = ncl; Enable = 1'b1;
        if (rdy != 12'hFFF) begin
            repeat (TMO_T - 1) @(negedge Clock);
            chk("tmo_early_busy", Busy, 0);
            chk("tmo_early_err", TmoErr, 0);
        end
        n = 0;
        while (Busy !== 1'b1 && n < 2000) begin @(negedge Clock); n++; end
        if (Busy !== 1'b1) begin chk("start_timeout", Busy, 1); q.delete(); return; end
        @(negedge Clock);
        #1;
        // Scramble every input mid-header; the event must run on the latched values.
        FCL = ~fcl; TagOut = ~tags; ChipNCL = ~ncl; Ready = 12'($urandom); Enable = 1'b0;
        if (rst_chip >= 0) begin
            n = 0;
            while (Send[rst_chip] !== 1'b1 && n < 500) begin @(negedge Clock); n++; end
            chk("rst_send_seen", Send[rst_chip], 1);
            repeat (3) @(negedge Clock);
            chk("pre_rst_serout", SerOut, 1);
            #2 Reset = 1'b0;
            #1;
            chk("rst_send", Send, 0);
            chk("rst_serout", SerOut, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_evtcnt", EvtCnt, 0);
            chk("rst_tagerr", TagErr, 0);
            chk("rst_tmoerr", TmoErr, 0);
            q.delete();
            Ready = 12'hFFF;
            repeat (3) @(negedge Clock);
            #1 Reset = 1'b1;
            return;
        end
        repeat (3) @(negedge Clock);
        Ready = rdy;
        n = 0;
        while (Busy !== 1'b0 && n < 3000) begin @(negedge Clock); n++; end
        chk("end_timeout", Busy, 0);
        chk("leftover_expect", q.size(), 0);
        q.delete();
        seen = 0;
        repeat (10) begin @(negedge Clock); if (Busy) seen = 1; end
        chk("no_restart", seen, 0);
    endtask

    initial begin
        Reset = 1'b0; Enable = 1'b0; Ready = '0; FCL = '0; TagOut = '0; ChipNCL = '0;
        ev_fcl = '0; ev_ncl = '0;
        repeat (3) @(negedge Clock);
        chk("reset_state", {Send, SerOut, Busy, TagErr, TmoErr, EvtCnt}, 0);
        #1 Reset = 1'b1;

        run_ev(12'hFFF, 12'h005, 24'hAAAAAA, 48'h777777777371, -1);
        chk("evt1_cnt", EvtCnt, 1);
        chk("evt1_tagerr", TagErr, 0);

        run_ev(12'hFFF, 12'h000, 24'h000000, 48'hFFFFFFFFFFFF, -1);
        chk("evt2_cnt", EvtCnt, 2);

        run_ev(12'hFFF, 12'h0A0, 24'h000400, 48'h000000000000, -1);
        chk("evt3_cnt", EvtCnt, 3);
        chk("evt3_tagerr", TagErr, 1);

        run_ev(12'hFFF, 12'h801, 24'hFFFFFF, 48'hF00000000000, -1);
        chk("evt4_cnt", EvtCnt, 4);
        chk("evt4_tagerr_sticky", TagErr, 1);

        run_ev(12'hFFF, 12'h008, 24'h000000, 48'h000000005000, 3);
        Enable = 1'b0;
        repeat (5) @(negedge Clock);
        chk("post_rst_idle", Busy, 0);
        chk("post_rst_cnt", EvtCnt, 0);

        run_ev(12'hFFF, 12'h002, 24'h555555, 48'h000000000020, -1);
        chk("evt6_cnt", EvtCnt, 1);
        chk("evt6_tagerr", TagErr, 0);
`ifdef DMS_TIMEOUT_EN
        run_ev(12'hF7F, 12'hFFF, 24'h000000, 48'h000000000000, -1);
        chk("tmo_err", TmoErr, 1);
        chk("tmo_cnt", EvtCnt, 2);
`else
        chk("tmo_tied", TmoErr, 0);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
